// File: rtl/clk_gate_enable_ctrl_pkg.sv
// Shared types and limits for the register-bank clock-gate enable controller.
package clk_gate_ctrl_pkg;

    // Width of the shared idle/wake down-counter.
    localparam int CNT_W = 16;

    // Upper bounds of the legal parameter ranges (lower bound is 1 for both).
    localparam int unsigned IDLE_CYCLES_MAX = 65535;
    localparam int unsigned WAKE_LAT_MAX    = 255;

    // Controller states. ST_GATED is the only state in which EN is deasserted.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

endpackage

// File: rtl/clk_gate_enable_ctrl_if.sv
// Control/status bundle between the clock-gate enable controller and its
// environment.
//
// Wake handshake (four-phase): the requester raises wake_req and holds it
// while it needs the clock; the controller raises wake_ack once the clock is
// running; the requester drops wake_req; the controller drops wake_ack on the
// same rising edge that samples wake_req low. wake_ack never rises while
// wake_req is low.
interface clk_gate_enable_ctrl_if;
    import clk_gate_ctrl_pkg::*;

    logic   active;     // downstream busy, clock needed
    logic   wake_req;   // four-phase wake request
    logic   halt;       // debug stop, drops TE
    logic   scan_mode;  // static during scan, forces the gate open
    logic   en;         // gate enable, changes only while CLK is low
    logic   te;         // gate test/enable term, changes only while CLK is low
    logic   wake_ack;   // four-phase wake acknowledge
    logic   gated;      // status: controller is in ST_GATED
    state_t state;      // debug view of the controller state

    // Environment side.
    modport master (
        output active, wake_req, halt, scan_mode,
        input  en, te, wake_ack, gated, state
    );

    // Controller side.
    modport slave (
        input  active, wake_req, halt, scan_mode,
        output en, te, wake_ack, gated, state
    );

endinterface

// File: rtl/clk_gate_en_retime.sv
// Falling-edge retiming of the EN/TE gate terms so they only change while CLK
// is low and cannot clip an ENCLK pulse.
module clk_gate_en_retime (
    input  logic clk,
    input  logic rst_n,
    input  logic en_tgt,
    input  logic te_tgt,
    output logic en,
    output logic te
);

    logic en_d, en_q;
    logic te_d, te_q;

    // Next values are simply the targets computed on the rising-edge side.
    always_comb begin
        en_d = en_tgt;
        te_d = te_tgt;
    end

    // Falling-edge flops; reset opens the gate (both terms high).
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b1;
            te_q <= 1'b1;
        end else begin
            en_q <= en_d;
            te_q <= te_d;
        end
    end

    assign en = en_q;
    assign te = te_q;

endmodule

// File: rtl/clk_gate_enable_ctrl.sv
// Enable controller for the register-bank integrated clock gate: gates the
// clock after a programmable idle period, restores it on activity or a
// four-phase wake request, and supports debug halt and scan override.
module clk_gate_enable_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_LAT    = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    clk_gate_enable_ctrl_if.slave bus
);

    // Reject out-of-range parameters at elaboration.
    if (IDLE_CYCLES < 1 || IDLE_CYCLES > IDLE_CYCLES_MAX) begin : g_bad_idle_cycles
        $error("IDLE_CYCLES out of range 1..%0d", IDLE_CYCLES_MAX);
    end
    if (WAKE_LAT < 1 || WAKE_LAT > WAKE_LAT_MAX) begin : g_bad_wake_lat
        $error("WAKE_LAT out of range 1..%0d", WAKE_LAT_MAX);
    end

    // Counter reload values; the counter runs down to zero inclusive, so a
    // load of N-1 yields N further edges before the transition.
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LAT - 1);

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             halt_d, halt_q;
    logic             wake_ack_d, wake_ack_q;
    logic             gated_d, gated_q;
    logic             demand;
    logic             en_tgt, te_tgt;
    logic             en_w, te_w;

    assign demand = bus.active || bus.wake_req;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        halt_d  = bus.halt;
        if (bus.scan_mode) begin
            // Scan holds the controller in RUN with the counter parked.
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!demand) begin
                        state_d = ST_IDLE;
                        cnt_d   = IDLE_LOAD;
                    end
                end
                ST_IDLE: begin
                    // A pending wake request keeps the clock running.
                    if (demand) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == '0) begin
                        state_d = ST_GATED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GATED: begin
                    // Activity and request together still produce one wake.
                    if (demand) begin
                        state_d = ST_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    // Inputs are ignored until the wake latency expires.
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
        wake_ack_d = bus.wake_req && (state_d == ST_RUN || state_d == ST_IDLE);
        gated_d    = (state_d == ST_GATED);
    end

    // Rising-edge state, counter and status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            halt_q     <= 1'b0;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_q     <= halt_d;
            wake_ack_q <= wake_ack_d;
            gated_q    <= gated_d;
        end
    end

    // Gate-term targets; scan overrides both halt and the state machine.
    always_comb begin
        en_tgt = bus.scan_mode || (state_q != ST_GATED);
        te_tgt = bus.scan_mode || !halt_q;
    end

    clk_gate_en_retime u_retime (
        .clk    (CLK),
        .rst_n  (RST_N),
        .en_tgt (en_tgt),
        .te_tgt (te_tgt),
        .en     (en_w),
        .te     (te_w)
    );

    assign bus.en       = en_w;
    assign bus.te       = te_w;
    assign bus.wake_ack = wake_ack_q;
    assign bus.gated    = gated_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_clk_gate_enable_ctrl.sv
// Directed bench for clk_gate_enable_ctrl with default parameters
// (IDLE_CYCLES=16, WAKE_LAT=2). Cycle n is the interval after rising edge n.
// Expected output vectors are queued per cycle by the driver and checked by a
// separate monitor in the low phase of that cycle, after the falling edge.
module tb_clk_gate_enable_ctrl;
    import clk_gate_ctrl_pkg::*;

    localparam int W = 30; // {cycle[15:0], mask[6:0], value[6:0]}

    logic clk;
    logic rst_n;
    int   cyc;
    logic pulse;
    int   checks;
    int   errors;

    logic [W-1:0] exp_q[$];
    string        nm_q[$];

    clk_gate_enable_ctrl_if bus ();

    clk_gate_enable_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_LAT    (2)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue an expectation for cycle c; -1 marks a don't-care field.
    // Vector bits: {enclk_pulse_at_edge, en, te, wake_ack, gated, state[1:0]}.
    task automatic chk(input int c, input string nm, input int p, input int e,
                       input int t, input int a, input int g, input int s);
        logic [6:0] m;
        logic [6:0] v;
        logic [15:0] cc;
        m  = '0;
        v  = '0;
        cc = c[15:0];
        if (p >= 0) begin m[6] = 1'b1; v[6] = p[0]; end
        if (e >= 0) begin m[5] = 1'b1; v[5] = e[0]; end
        if (t >= 0) begin m[4] = 1'b1; v[4] = t[0]; end
        if (a >= 0) begin m[3] = 1'b1; v[3] = a[0]; end
        if (g >= 0) begin m[2] = 1'b1; v[2] = g[0]; end
        if (s >= 0) begin m[1:0] = 2'b11; v[1:0] = s[1:0]; end
        exp_q.push_back({cc, m, v});
        nm_q.push_back(nm);
    endtask

    // Drive point: low phase of the current cycle, inputs land on the next edge.
    task automatic step();
        @(negedge clk);
        #4;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // Monitor: count edges, record whether the gate passed this edge, then
    // compare every expectation due for this cycle.
    initial begin
        logic [W-1:0] ent;
        logic [6:0]   got;
        string        nm;
        cyc    = 0;
        checks = 0;
        errors = 0;
        pulse  = 1'b0;
        forever begin
            @(posedge clk);
            cyc   = cyc + 1;
            pulse = bus.en & bus.te;
            @(negedge clk);
            #2;
            got = {pulse, bus.en, bus.te, bus.wake_ack, bus.gated, bus.state};
            while (exp_q.size() != 0 && int'(exp_q[0][29:14]) <= cyc) begin
                ent    = exp_q.pop_front();
                nm     = nm_q.pop_front();
                checks = checks + 1;
                if (int'(ent[29:14]) < cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d expectation not sampled in time (now %0d)",
                             nm, int'(ent[29:14]), cyc);
                end else if ((got & ent[13:7]) !== (ent[6:0] & ent[13:7])) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got {p,en,te,ack,gated,st}=%b exp=%b mask=%b",
                             nm, cyc, got, ent[6:0], ent[13:7]);
                end
            end
        end
    end

    // Driver: directed scenario with hand-computed expectations.
    initial begin
        rst_n         = 1'b0;
        bus.active    = 1'b1;
        bus.wake_req  = 1'b0;
        bus.halt      = 1'b0;
        bus.scan_mode = 1'b0;

        // Reset values, then a busy RUN period.
        chk(2,  "reset",            -1, 1, 1, 0, 0, 0);
        chk(5,  "run_active",        1, 1, 1, 0, 0, 0);
        goto(2);
        rst_n = 1'b1;

        // Idle from edge 10: IDLE, gate at edge 26, no pulses afterwards.
        chk(10, "idle_enter",        1, 1, 1, 0, 0, 1);
        chk(25, "idle_last",         1, 1, 1, 0, 0, 1);
        chk(26, "gate_enter",        1, 0, 1, 0, 1, 2);
        chk(27, "gated_nopulse",     0, 0, 1, 0, 1, 2);
        chk(35, "gated_hold",        0, 0, 1, 0, 1, 2);
        goto(9);
        bus.active = 1'b0;

        // Wake request sampled at edge 40; ACK at 42; REQ drop at 45.
        chk(40, "wake_en",           0, 1, 1, 0, 0, 3);
        chk(41, "wake_pulse",        1, 1, 1, 0, 0, 3);
        chk(42, "wake_ack",          1, 1, 1, 1, 0, 0);
        chk(44, "ack_hold",          1, 1, 1, 1, 0, 0);
        chk(45, "ack_drop",          1, 1, 1, 0, 0, 1);
        goto(39);
        bus.wake_req = 1'b1;
        goto(44);
        bus.wake_req = 1'b0;

        // One-cycle ACTIVE pulse mid-count restarts the idle period.
        chk(50, "active_pulse",      1, 1, 1, 0, 0, 0);
        chk(51, "reidle",            1, 1, 1, 0, 0, 1);
        chk(66, "reidle_last",       1, 1, 1, 0, 0, 1);
        chk(67, "regate",            1, 0, 1, 0, 1, 2);
        goto(49);
        bus.active = 1'b1;
        goto(50);
        bus.active = 1'b0;

        // ACTIVE and WAKE_REQ together: a single wake.
        chk(70, "dual_wake",         0, 1, 1, 0, 0, 3);
        chk(71, "dual_wake_single",  1, 1, 1, 0, 0, 3);
        chk(72, "dual_ack",          1, 1, 1, 1, 0, 0);
        chk(75, "dual_ack_drop",     1, 1, 1, 0, 0, 0);
        goto(69);
        bus.active   = 1'b1;
        bus.wake_req = 1'b1;
        goto(74);
        bus.wake_req = 1'b0;

        // HALT at edge 80: TE drops, EN stays; idle counting continues.
        chk(79, "pre_halt",          1, 1, 1, 0, 0, 0);
        chk(80, "halt_te",           1, 1, 0, 0, 0, 0);
        chk(81, "halt_nopulse",      0, 1, 0, 0, 0, 0);
        chk(82, "halt_idle_count",   0, 1, 0, 0, 0, 1);
        chk(83, "halt_hold",         0, 1, 0, 0, 0, 1);
        chk(84, "halt_release",      0, 1, 1, 0, 0, 1);
        chk(85, "halt_release_pulse",1, 1, 1, 0, 0, 1);
        chk(97, "halt_idle_last",    1, 1, 1, 0, 0, 1);
        chk(98, "halt_gate",         1, 0, 1, 0, 1, 2);
        goto(79);
        bus.halt = 1'b1;
        goto(81);
        bus.active = 1'b0;
        goto(83);
        bus.halt = 1'b0;

        // SCAN while GATED: gate opens at the next falling edge, HALT ignored.
        chk(100, "pre_scan",         0, 0, 1, 0, 1, 2);
        chk(101, "scan_open",        0, 1, 1, 0, 0, 0);
        chk(102, "scan_run",         1, 1, 1, 0, 0, 0);
        chk(105, "scan_ignore",      1, 1, 1, 0, 0, 0);
        chk(106, "scan_exit",        1, 1, 1, 0, 0, 1);
        goto(100);
        bus.scan_mode = 1'b1;
        bus.halt      = 1'b1;
        goto(105);
        bus.scan_mode = 1'b0;
        bus.halt      = 1'b0;

        // Reset asserted during WAKE (with HALT holding TE low).
        chk(122, "gate3",            1, 0, 1, 0, 1, 2);
        chk(124, "gated_halt",       0, 0, 0, 0, 1, 2);
        chk(125, "wake3",            0, 1, 0, 0, 0, 3);
        chk(126, "rst_in_wake",      0, 1, 1, 0, 0, 0);
        chk(128, "post_rst",         1, 1, 1, 0, 0, 0);
        goto(123);
        bus.halt = 1'b1;
        goto(124);
        bus.wake_req = 1'b1;
        goto(125);
        rst_n = 1'b0;
        goto(127);
        rst_n        = 1'b1;
        bus.wake_req = 1'b0;
        bus.halt     = 1'b0;
        bus.active   = 1'b1;

        // WAKE_REQ in RUN: acknowledged on the sampling edge.
        chk(129, "run_no_ack",       1, 1, 1, 0, 0, 0);
        chk(130, "run_ack",          1, 1, 1, 1, 0, 0);
        chk(133, "run_ack_drop",     1, 1, 1, 0, 0, 0);
        goto(129);
        bus.wake_req = 1'b1;
        goto(132);
        bus.wake_req = 1'b0;

        // Drain the scoreboard with a bounded wait.
        goto(140);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain %0d expectations never checked (need 0)", exp_q.size());
            checks = checks + exp_q.size();
            errors = errors + exp_q.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
